// File: rtl/instr_memory_pkg.sv
// Shared CPU constants: instruction word width, program-pointer width and
// instruction-memory depth used by both the PC logic and the memory.
package instr_memory_pkg;

    localparam int INSTR_W = 26;
    localparam int PC_W    = 4;
    localparam int DEPTH   = 2 ** PC_W;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/instr_memory.sv
// 16 x 26-bit single-port instruction memory: each edge either writes a word
// or performs a registered read of the addressed word onto opcode.
module instr_memory
    import instr_memory_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] prog_pointer,
    input  logic              write_data,
    input  logic [DATA_W-1:0] data_to_write,
    output logic [DATA_W-1:0] opcode
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is plain flops so every entry is defined right after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_data) begin
            mem[prog_pointer] <= data_to_write;
        end else begin
            opcode <= mem[prog_pointer];
        end
    end

endmodule

// File: tb/tb_instr_memory.sv
// Directed self-checking bench for instr_memory: reset, write/read, overwrite,
// full address sweep, reset mid-operation and writes ignored during reset.
module tb_instr_memory;

    logic        clk;
    logic        reset;
    logic [3:0]  prog_pointer;
    logic        write_data;
    logic [25:0] data_to_write;
    logic [25:0] opcode;

    int tests_run;
    int tests_failed;

    instr_memory dut (
        .clk          (clk),
        .reset        (reset),
        .prog_pointer (prog_pointer),
        .write_data   (write_data),
        .data_to_write(data_to_write),
        .opcode       (opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [25:0] d);
        prog_pointer  = a;
        write_data    = 1'b1;
        data_to_write = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a);
        prog_pointer  = a;
        write_data    = 1'b0;
        data_to_write = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset         = 1'b1;
        prog_pointer  = '0;
        write_data    = 1'b0;
        data_to_write = '0;

        // Reset asserted between edges clears opcode immediately
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_opcode", opcode, 26'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Every entry reads back zero after reset
        for (int k = 0; k < 16; k++) begin
            do_read(4'(k));
            check($sformatf("reset_entry_%0d", k), opcode, 26'h0);
        end

        // Write 5555 to address 3: opcode held during the write
        do_read(4'd0);
        do_write(4'd3, 26'h0005555);
        check("write_no_writethrough", opcode, 26'h0);
        do_read(4'd3);
        check("read_5555", opcode, 26'h0005555);

        // Back-to-back writes: last wins; opcode still holds old read
        do_write(4'd3, 26'h0005555);
        do_write(4'd3, 26'h000AAAA);
        check("hold_over_writes", opcode, 26'h0005555);
        do_read(4'd3);
        check("overwrite_AAAA", opcode, 26'h000AAAA);

        // Sweep: write k to address k, read back descending
        for (int k = 0; k < 16; k++) begin
            do_write(4'(k), 26'(k));
        end
        for (int k = 15; k >= 0; k--) begin
            do_read(4'(k));
            check($sformatf("sweep_%0d", k), opcode, 26'(k));
        end

        // Load all-ones, read it, then reset between edges
        do_write(4'd7, 26'h3FFFFFF);
        do_read(4'd7);
        check("read_all_ones", opcode, 26'h3FFFFFF);
        #2;
        reset = 1'b0;
        #1;
        check("reset_midop_opcode", opcode, 26'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_read(4'd7);
        check("reset_midop_entry7", opcode, 26'h0);
        do_read(4'd15);
        check("reset_midop_entry15", opcode, 26'h0);

        // Writes ignored while reset held low
        reset = 1'b0;
        prog_pointer  = 4'd2;
        write_data    = 1'b1;
        data_to_write = 26'h1234567;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_opcode", opcode, 26'h0);
        reset = 1'b1;
        do_read(4'd2);
        check("write_ignored_in_reset", opcode, 26'h0);

        // Normal operation after that release
        do_write(4'd2, 26'h1234567);
        do_read(4'd2);
        check("post_release_write", opcode, 26'h1234567);
        do_read(4'd0);
        check("post_release_entry0", opcode, 26'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_memory.md
Name: instr_memory

Overview:
- Small instruction memory for the CPU: 16 entries x 26-bit opcode words, addressed by the program pointer.
- Single port: each clock edge performs either a write of new instruction data or a registered read of the addressed word onto opcode.
- Sits between the program-counter logic (supplies prog_pointer) and the instruction decoder (consumes opcode).
- Also serves as the program-load path.

Parameters:
- DATA_W, 26, width of one instruction word / opcode.
- ADDR_W, 4, width of prog_pointer.
- DEPTH, 16, number of entries (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- prog_pointer  input  ADDR_W  address of the entry to read or write.
- write_data  input  1  operation select: 1 = write, 0 = read.
- data_to_write  input  DATA_W  word stored when write_data = 1.
- opcode  output  DATA_W  registered read data.

Behaviour:
- Reset (reset = 0, asynchronous, independent of clk):
  - opcode clears to 0 immediately.
  - All DEPTH entries clear to 0.
  - While reset is held low, writes are ignored and opcode stays 0.
  - Release is synchronous in effect: the first operation occurs on the first rising edge with reset = 1.
- Write (rising edge, reset = 1, write_data = 1):
  - mem[prog_pointer] <= data_to_write.
  - opcode holds its previous value; no write-through.
- Read (rising edge, reset = 1, write_data = 0):
  - opcode <= mem[prog_pointer].
  - Latency: 1 clock; opcode is valid after the edge that samples the address.
  - Holds until the next read edge or reset.
- Read after write to the same address on the following edge returns the newly written word.
- Back-to-back writes to one address: last write wins.
- Address range: prog_pointer covers 0..15 exactly; no out-of-range case and no wrap logic needed.
- Width rule: narrower stimulus is zero-extended by the driver. Example: 16'h5555 is stored as 26'h0005555.
- No handshake: every enabled edge completes in one cycle.
- No X propagation: every entry holds a defined value after reset.

Decomposition:
- Shared CPU package holds:
  - INSTR_W = 26 and PC_W = 4 constants.
  - An instr_t typedef (logic [INSTR_W-1:0]).
  - DEPTH, shared with the program counter.
- No sub-module. The storage array, reset clear loop, and output register live in one module.

Test Plan:
- Reset: drive reset = 0 mid-cycle with no clock edge -> opcode = 0 immediately. After release, read addresses 0..15 -> opcode = 0 at each.
- Write/read 5555: for address 3, write 26'h0005555, then read on the next edge -> opcode = 26'h0005555 one cycle after the read edge. opcode is unchanged during the write cycle.
- Overwrite: address 3 write 26'h0005555, then write 26'h000AAAA, then read -> opcode = 26'h000AAAA.
- Sweep: write address k with {22'h0, k} for k = 0..15, then read 15 down to 0 -> opcode = k each cycle, 1-cycle latency. Address 15 and address 0 are not aliased.
- Reset mid-operation: load address 7 = 26'h3FFFFFF, assert reset between edges -> opcode = 0 at once. After release, read 7 -> 0.
- Write ignored in reset: with reset = 0, write_data = 1, data 26'h1234567 to address 2 across edges. Release and read 2 -> 0.
